// File: rtl/rr_grant_scheduler_pkg.sv
// rtl/rr_grant_scheduler_pkg.sv - shared types for the round-robin grant scheduler
package rr_grant_scheduler_pkg;

  localparam int MAX_REQUESTERS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    LOCKED = 2'd2
  } scheduler_state_t;

endpackage

// File: rtl/idx_to_oh.sv
// rtl/idx_to_oh.sv - binary index to LSB0 one-hot decoder
module idx_to_oh #(
  parameter int NUM_BITS    = 4,
  parameter int INDEX_WIDTH = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic [INDEX_WIDTH-1:0] idx,
  output logic [NUM_BITS-1:0]    oh
);

  always_comb begin
    oh = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (int'(idx) == i) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_scheduler_pick.sv
// rtl/rr_grant_scheduler_pick.sv - rotating-priority search starting at a pointer
module rr_grant_scheduler_pick #(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic [NUM_REQUESTERS-1:0] cand,
  input  logic [INDEX_WIDTH-1:0]    ptr,
  output logic                      found,
  output logic [INDEX_WIDTH-1:0]    idx
);

  int pos;

  // Scan from farthest to nearest so the position closest to ptr is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQUESTERS) pos = pos - NUM_REQUESTERS;
      if (cand[pos]) begin
        found = 1'b1;
        idx   = pos[INDEX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin grant scheduler with offer/accept and locked bursts
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      lock,
  input  logic                      grant_accept,
  output logic                      grant_valid,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [INDEX_WIDTH-1:0]    grant_idx
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  scheduler_state_t              state;
  logic [INDEX_WIDTH-1:0]        ptr;
  logic [INDEX_WIDTH-1:0]        ptr_next;
  logic [NUM_REQUESTERS-1:0]     raw_oh;
  logic [NUM_REQUESTERS-1:0]     cand_rest;
  logic                          cur_found;
  logic [INDEX_WIDTH-1:0]        cur_idx;
  logic                          next_found;
  logic [INDEX_WIDTH-1:0]        next_idx;

  idx_to_oh #(
    .NUM_BITS    (NUM_REQUESTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_idx_to_oh (
    .idx (grant_idx),
    .oh  (raw_oh)
  );

  assign grant_oh  = grant_valid ? raw_oh : '0;
  assign ptr_next  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  assign cand_rest = request & ~grant_oh;

  // Fresh arbitration with the current pointer (idle start or withdrawal).
  rr_grant_scheduler_pick #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .INDEX_WIDTH    (INDEX_WIDTH)
  ) u_pick_cur (
    .cand  (request),
    .ptr   (ptr),
    .found (cur_found),
    .idx   (cur_idx)
  );

  // Back-to-back successor after a completed grant, excluding the holder.
  rr_grant_scheduler_pick #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .INDEX_WIDTH    (INDEX_WIDTH)
  ) u_pick_next (
    .cand  (cand_rest),
    .ptr   (ptr_next),
    .found (next_found),
    .idx   (next_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cur_found) begin
            state       <= OFFER;
            grant_valid <= 1'b1;
            grant_idx   <= cur_idx;
          end
        end
        OFFER: begin
          if (grant_accept) begin
            if (lock) begin
              state <= LOCKED;
            end else begin
              ptr <= ptr_next;
              if (next_found) begin
                grant_idx <= next_idx;
              end else begin
                state       <= IDLE;
                grant_valid <= 1'b0;
                grant_idx   <= '0;
              end
            end
          end else if (!request[grant_idx]) begin
            if (cur_found) begin
              grant_idx <= cur_idx;
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              grant_idx   <= '0;
            end
          end
        end
        LOCKED: begin
          if (grant_accept && !lock) begin
            ptr <= ptr_next;
            if (next_found) begin
              state     <= OFFER;
              grant_idx <= next_idx;
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              grant_idx   <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          grant_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - directed scoreboard bench for rr_grant_scheduler
module tb_rr_grant_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] request;
  logic       lock;
  logic       grant_accept;
  logic       grant_valid;
  logic [3:0] grant_oh;
  logic [1:0] grant_idx;

  typedef struct packed {
    logic       v;
    logic [1:0] idx;
    logic [3:0] oh;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  rr_grant_scheduler #(
    .NUM_REQUESTERS (4),
    .INDEX_WIDTH    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .lock         (lock),
    .grant_accept (grant_accept),
    .grant_valid  (grant_valid),
    .grant_oh     (grant_oh),
    .grant_idx    (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic v, input logic [1:0] idx);
    exp_t e;
    e.v   = v;
    e.idx = v ? idx : 2'd0;
    e.oh  = v ? (4'b0001 << idx) : 4'b0000;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty got valid=%0b want an entry", tag, grant_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (grant_valid === e.v) else begin
        errors++;
        $error("FAIL %s valid got %0b want %0b", tag, grant_valid, e.v);
      end
      checks++;
      assert (grant_idx === e.idx) else begin
        errors++;
        $error("FAIL %s idx got %0d want %0d", tag, grant_idx, e.idx);
      end
      checks++;
      assert (grant_oh === e.oh) else begin
        errors++;
        $error("FAIL %s oh got %b want %b", tag, grant_oh, e.oh);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #2;
    check_now(tag);
  endtask

  task automatic step(input logic [3:0] req, input logic acc, input logic lk,
                      input logic ev, input logic [1:0] eidx, input string tag);
    request      = req;
    grant_accept = acc;
    lock         = lk;
    push_exp(ev, eidx);
    tick(tag);
  endtask

  task automatic do_reset(input string tag);
    request      = 4'b0000;
    grant_accept = 1'b0;
    lock         = 1'b0;
    reset        = 1'b0;
    #1;
    push_exp(1'b0, 2'd0);
    check_now(tag);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    request      = 4'b0000;
    lock         = 1'b0;
    grant_accept = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    push_exp(1'b0, 2'd0);
    check_now("reset_state");
    reset = 1'b1;

    // Idle with stray accept/lock: nothing may be granted.
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, "idle_zero");

    step(4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, "rr_full_0");
    step(4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, "rr_full_1");
    step(4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, "rr_full_2");
    step(4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, "rr_full_3");
    step(4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, "rr_full_wrap");
    step(4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, "rr_full_1b");
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, "rr_full_drain");

    do_reset("reset_b");
    step(4'b1010, 1'b0, 1'b0, 1'b1, 2'd1, "sparse_first");
    step(4'b1010, 1'b1, 1'b0, 1'b1, 2'd3, "sparse_next");
    step(4'b1010, 1'b1, 1'b0, 1'b1, 2'd1, "sparse_wrap");
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, "sparse_drain");

    do_reset("reset_c");
    step(4'b0011, 1'b0, 1'b0, 1'b1, 2'd0, "lock_offer");
    step(4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, "lock_beat1");
    step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "lock_withdraw_ignored");
    step(4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, "lock_beat2");
    step(4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, "lock_beat3");
    step(4'b0011, 1'b1, 1'b0, 1'b1, 2'd1, "lock_release");
    step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, "lock_drain");

    do_reset("reset_d");
    step(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, "withdraw_offer");
    step(4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, "withdraw_rearb");
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "withdraw_all");

    do_reset("reset_e");
    step(4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, "rst_lock_offer");
    step(4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, "rst_lock_enter");
    step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, "rst_lock_hold");
    #3;
    reset = 1'b0;
    #1;
    push_exp(1'b0, 2'd0);
    check_now("rst_async");
    request = 4'b1111;
    push_exp(1'b0, 2'd0);
    tick("rst_held");
    reset = 1'b1;
    step(4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, "rst_first_arb");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQUESTERS, default 4, giving the number of requesters (legal range 1..32).
REQ-002 The block SHALL have parameter INDEX_WIDTH, default $clog2(NUM_REQUESTERS), with a minimum of 1, giving the width of the grant index.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port request, input, NUM_REQUESTERS bits: one bit per requester; bit i high means requester i wants the resource.
REQ-006 The block SHALL have port lock, input, 1 bit: sampled with grant_accept; when high, the current grant is held for further beats.
REQ-007 The block SHALL have port grant_accept, input, 1 bit: the resource consumed the offered grant this cycle.
REQ-008 The block SHALL have port grant_valid, output, 1 bit: a registered grant is being offered.
REQ-009 The block SHALL have port grant_oh, output, NUM_REQUESTERS bits: registered one-hot grant, LSB0 (bit 0 is requester 0), all zero when grant_valid is low.
REQ-010 The block SHALL have port grant_idx, output, INDEX_WIDTH bits: binary index of the granted requester, 0 when grant_valid is low.

Function
REQ-011 The block SHALL implement states IDLE, OFFER and LOCKED.
REQ-012 The block SHALL keep a priority pointer; arbitration selects the first set bit of the candidate vector scanning upward from the pointer, wrapping from NUM_REQUESTERS-1 to 0.
REQ-013 In IDLE, when request is nonzero in cycle N, the block SHALL present grant_valid=1 with the arbitration winner in cycle N+1 and enter OFFER; with request zero it SHALL stay in IDLE.
REQ-014 In OFFER, grant_oh and grant_idx SHALL remain stable until accept, withdrawal or reset.
REQ-015 In OFFER, on grant_accept=1 with lock=0, the pointer SHALL become (grant_idx+1) mod NUM_REQUESTERS; in the next cycle the block SHALL offer the winner among request & ~grant_oh using the new pointer (back-to-back, no bubble), or go to IDLE with grant_valid=0 when no candidate exists.
REQ-016 In OFFER, on grant_accept=1 with lock=1, the block SHALL enter LOCKED, keep the same grant and leave the pointer unchanged.
REQ-017 In OFFER, when request[grant_idx]=0 and grant_accept=0 (withdrawal), the block SHALL re-arbitrate over request with the pointer unchanged and update the outputs in the next cycle.
REQ-018 In LOCKED, grant_valid SHALL stay 1 with the grant unchanged; request withdrawal SHALL be ignored; grant_accept with lock=1 SHALL remain in LOCKED.
REQ-019 In LOCKED, grant_accept=1 with lock=0 SHALL end the burst and be handled exactly as REQ-015.
REQ-020 The block SHALL ignore grant_accept and lock while grant_valid=0.
REQ-021 The pointer SHALL wrap correctly for non-power-of-two NUM_REQUESTERS and never hold a value of NUM_REQUESTERS or above.
REQ-022 When NUM_REQUESTERS=1, the block SHALL always grant index 0 whenever request[0] is high.

Reset
REQ-023 Assertion of reset (low) SHALL immediately force grant_valid=0, grant_oh=0, grant_idx=0, pointer=0 and state IDLE, in any state including LOCKED.
REQ-024 After reset deasserts, the first arbitration SHALL give requester 0 the highest priority.

Structure
REQ-025 The state enum type scheduler_state_t SHALL be defined in the shared defines package.
REQ-026 grant_oh SHALL be derived from the registered grant_idx through one instance of the existing idx_to_oh module (LSB0), gated by grant_valid.
REQ-027 The rotating-priority search SHALL be combinational, with only state, pointer, grant_idx and grant_valid registered.

Verification (NUM_REQUESTERS=4)
REQ-028 The bench SHALL check: reset released with request=0000 for 10 cycles -> grant_valid=0 and grant_oh=0000 every cycle.
REQ-029 The bench SHALL check: request=1111 held, grant_accept=1 every cycle -> grant_idx 0,1,2,3,0,1 on consecutive cycles with no bubble.
REQ-030 The bench SHALL check: request=1010 after reset -> grant_idx=1 one cycle later; accept -> 3; accept -> 1.
REQ-031 The bench SHALL check: request=0011 and grant 0 accepted with lock=1 for 3 beats, then accepted with lock=0 -> grant_idx=0 for all 4 beats, then 1.
REQ-032 The bench SHALL check: request=0100, grant 2 offered, then request changes to 0001 without accept -> next cycle grant_idx=0 and grant_oh=0001.
REQ-033 The bench SHALL check: reset asserted mid-cycle while in LOCKED on grant 3 -> grant_valid=0 and grant_oh=0000 before the next clock edge; after release with request=1111 -> grant_idx=0.
